scalable_stage_controller: RTL

- Next-generation union-find decoder stage sequencer. Coordinates NUM_LEAVES processing-unit arrays or FPGA leaves through the loading, spread, sync and grow stages, then the result stages.
- New over the single-array controller:
  - per-leaf status handshake with sticky collection
  - multi-cycle measurement loading
  - bounded iteration count
  - calculator go/done handshake
  - held result with ready/valid acknowledge
- Sits between the round scheduler/host interface and the PU arrays plus the boundary-cardinality calculator.

---
 rtl/scalable_stage_controller_pkg.sv | 23 ++
 rtl/scalable_stage_controller_if.sv | 38 +++
 rtl/leaf_status_aggregator.sv | 47 ++++
 rtl/scalable_stage_controller.sv | 135 +++++++++++++
 4 files changed

// File: rtl/scalable_stage_controller_pkg.sv
// Shared stage encodings and helpers for the union-find stage sequencer.
// Stage values are broadcast to the leaf arrays, so the encodings are fixed.
package scalable_stage_controller_pkg;

  localparam int STAGE_WIDTH = 3;

  typedef enum logic [STAGE_WIDTH-1:0] {
    IDLE                = 3'd0,
    SPREAD_CLUSTER      = 3'd1,
    GROW_BOUNDARY       = 3'd2,
    SYNC_IS_ODD_CLUSTER = 3'd3,
    MEASUREMENT_LOADING = 3'd4,
    RESULT_CALCULATING  = 3'd5,
    RESULT_HOLD         = 3'd6
  } stage_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/scalable_stage_controller_if.sv
// Host, leaf and calculator signals of the stage sequencer, bundled as one interface.
// The slave modport is the controller's view; master is the surrounding system.
interface scalable_stage_controller_if
  import scalable_stage_controller_pkg::*;
#(
  parameter int NUM_LEAVES              = 4,
  parameter int ITERATION_COUNTER_WIDTH = 8
);
  logic                               new_round_start;
  logic                               load_done;
  logic [NUM_LEAVES-1:0]              leaf_status_valid;
  logic [NUM_LEAVES-1:0]              leaf_has_message_flying;
  logic [NUM_LEAVES-1:0]              leaf_has_odd_clusters;
  logic                               calc_done;
  logic                               result_ready;
  logic [STAGE_WIDTH-1:0]             stage;
  logic                               calc_go;
  logic                               result_valid;
  logic [ITERATION_COUNTER_WIDTH-1:0] iteration_counter;
  logic [31:0]                        cycle_counter;
  logic                               deadlock;
  logic                               iteration_limit_hit;
  logic                               busy;

  modport master (
    output new_round_start, load_done, leaf_status_valid, leaf_has_message_flying,
           leaf_has_odd_clusters, calc_done, result_ready,
    input  stage, calc_go, result_valid, iteration_counter, cycle_counter,
           deadlock, iteration_limit_hit, busy
  );

  modport slave (
    input  new_round_start, load_done, leaf_status_valid, leaf_has_message_flying,
           leaf_has_odd_clusters, calc_done, result_ready,
    output stage, calc_go, result_valid, iteration_counter, cycle_counter,
           deadlock, iteration_limit_hit, busy
  );
endinterface

// File: rtl/leaf_status_aggregator.sv
// Sticky per-leaf status capture; each leaf's latest strobe wins until clear.
// Strobes arriving while clear is high are dropped so a new stage starts empty.
module leaf_status_aggregator #(
  parameter int NUM_LEAVES = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic [NUM_LEAVES-1:0] leaf_status_valid,
  input  logic [NUM_LEAVES-1:0] leaf_has_message_flying,
  input  logic [NUM_LEAVES-1:0] leaf_has_odd_clusters,
  output logic                  all_valid,
  output logic                  any_flying,
  output logic                  any_odd
);
  logic [NUM_LEAVES-1:0] reported;
  logic [NUM_LEAVES-1:0] flying;
  logic [NUM_LEAVES-1:0] odd;

  generate
    for (genvar gi = 0; gi < NUM_LEAVES; gi++) begin : g_leaf
      logic reported_reg;
      logic flying_reg;
      logic odd_reg;

      always_ff @(posedge clk) begin
        if (reset || clear) begin
          reported_reg <= 1'b0;
          flying_reg   <= 1'b0;
          odd_reg      <= 1'b0;
        end else if (leaf_status_valid[gi]) begin
          reported_reg <= 1'b1;
          flying_reg   <= leaf_has_message_flying[gi];
          odd_reg      <= leaf_has_odd_clusters[gi];
        end
      end

      assign reported[gi] = reported_reg;
      assign flying[gi]   = flying_reg;
      assign odd[gi]      = odd_reg;
    end
  endgenerate

  assign all_valid  = &reported;
  assign any_flying = |(reported & flying);
  assign any_odd    = |(reported & odd);
endmodule

// File: rtl/scalable_stage_controller.sv
// Union-find decoder stage sequencer: loading, spread/sync/grow loop, then result.
// Spread and sync visits are bounded by a stall counter that aborts to IDLE.
module scalable_stage_controller
  import scalable_stage_controller_pkg::*;
#(
  parameter int NUM_LEAVES              = 4,
  parameter int ITERATION_COUNTER_WIDTH = 8,
  parameter int MAX_ITERATIONS          = 200,
  parameter int GROW_DELAY              = 3,
  parameter int SPREAD_DELAY            = 2,
  parameter int SYNC_DELAY              = 2,
  parameter int DEADLOCK_THRESHOLD      = 4096
) (
  input logic                        clk,
  input logic                        reset,
  scalable_stage_controller_if.slave bus
);
  localparam int MAX_DELAY   = max3(GROW_DELAY, SPREAD_DELAY, SYNC_DELAY);
  localparam int DELAY_WIDTH = (MAX_DELAY < 1) ? 1 : $clog2(MAX_DELAY + 1);
  localparam int STALL_WIDTH = $clog2(DEADLOCK_THRESHOLD + 2);
  localparam logic [DELAY_WIDTH-1:0] DELAY_MAX = DELAY_WIDTH'(MAX_DELAY);

  stage_t                             stage_reg, stage_next;
  logic [DELAY_WIDTH-1:0]             delay_reg, delay_next;
  logic [STALL_WIDTH-1:0]             stall_reg, stall_next;
  logic [ITERATION_COUNTER_WIDTH-1:0] iter_reg, iter_next;
  logic [31:0]                        cycle_reg, cycle_next;
  logic                               deadlock_reg, deadlock_next;
  logic                               limit_reg, limit_next;
  logic                               entered_reg;
  logic                               stage_change, in_loop, settled, stalled;
  logic                               all_valid, any_flying, any_odd;

  assign stage_change = (stage_next != stage_reg);
  assign in_loop      = (stage_reg == SPREAD_CLUSTER) || (stage_reg == SYNC_IS_ODD_CLUSTER);
  assign settled      = all_valid && !any_flying;
  assign stalled      = stall_reg > STALL_WIDTH'(DEADLOCK_THRESHOLD);

  leaf_status_aggregator #(.NUM_LEAVES(NUM_LEAVES)) u_aggregator (
    .clk                     (clk),
    .reset                   (reset),
    .clear                   (stage_change),
    .leaf_status_valid       (bus.leaf_status_valid),
    .leaf_has_message_flying (bus.leaf_has_message_flying),
    .leaf_has_odd_clusters   (bus.leaf_has_odd_clusters),
    .all_valid               (all_valid),
    .any_flying              (any_flying),
    .any_odd                 (any_odd)
  );

  always_comb begin
    stage_next    = stage_reg;
    iter_next     = iter_reg;
    deadlock_next = deadlock_reg;
    limit_next    = limit_reg;
    cycle_next    = cycle_reg;
    if (stage_reg != IDLE && stage_reg != RESULT_HOLD) cycle_next = cycle_reg + 32'd1;

    case (stage_reg)
      IDLE: if (bus.new_round_start) begin
        stage_next    = MEASUREMENT_LOADING;
        deadlock_next = 1'b0;
        limit_next    = 1'b0;
        iter_next     = '0;
        cycle_next    = 32'd1;
      end
      MEASUREMENT_LOADING: if (bus.load_done) stage_next = SPREAD_CLUSTER;
      SPREAD_CLUSTER: begin
        if (stalled) begin
          deadlock_next = 1'b1;
          stage_next    = IDLE;
        end else if (delay_reg >= DELAY_WIDTH'(SPREAD_DELAY) && settled) begin
          stage_next = SYNC_IS_ODD_CLUSTER;
        end
      end
      SYNC_IS_ODD_CLUSTER: begin
        if (stalled) begin
          deadlock_next = 1'b1;
          stage_next    = IDLE;
        end else if (delay_reg >= DELAY_WIDTH'(SYNC_DELAY) && settled) begin
          if (!any_odd) begin
            stage_next = RESULT_CALCULATING;
          end else if (iter_reg < ITERATION_COUNTER_WIDTH'(MAX_ITERATIONS)) begin
            iter_next  = iter_reg + ITERATION_COUNTER_WIDTH'(1);
            stage_next = GROW_BOUNDARY;
          end else begin
            limit_next = 1'b1;
            stage_next = RESULT_CALCULATING;
          end
        end
      end
      GROW_BOUNDARY: if (delay_reg >= DELAY_WIDTH'(GROW_DELAY)) stage_next = SPREAD_CLUSTER;
      RESULT_CALCULATING: if (bus.calc_done) stage_next = RESULT_HOLD;
      RESULT_HOLD: if (bus.result_ready) stage_next = IDLE;
      default: stage_next = IDLE;
    endcase

    delay_next = '0;
    if (!stage_change) delay_next = (delay_reg < DELAY_MAX) ? delay_reg + DELAY_WIDTH'(1) : delay_reg;
    stall_next = '0;
    if (!stage_change && in_loop) stall_next = stall_reg + STALL_WIDTH'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stage_reg    <= IDLE;
      delay_reg    <= '0;
      stall_reg    <= '0;
      iter_reg     <= '0;
      cycle_reg    <= '0;
      deadlock_reg <= 1'b0;
      limit_reg    <= 1'b0;
      entered_reg  <= 1'b0;
    end else begin
      stage_reg    <= stage_next;
      delay_reg    <= delay_next;
      stall_reg    <= stall_next;
      iter_reg     <= iter_next;
      cycle_reg    <= cycle_next;
      deadlock_reg <= deadlock_next;
      limit_reg    <= limit_next;
      entered_reg  <= stage_change;
    end
  end

  // calc_go is tied to the first cycle after entering RESULT_CALCULATING
  assign bus.stage               = stage_reg;
  assign bus.calc_go             = (stage_reg == RESULT_CALCULATING) && entered_reg;
  assign bus.result_valid        = (stage_reg == RESULT_HOLD);
  assign bus.iteration_counter   = iter_reg;
  assign bus.cycle_counter       = cycle_reg;
  assign bus.deadlock            = deadlock_reg;
  assign bus.iteration_limit_hit = limit_reg;
  assign bus.busy                = (stage_reg != IDLE) && (stage_reg != RESULT_HOLD);
endmodule
